// File: rtl/painel_scroll_ctrl_if.sv
// Bundle of control/data signals between the panel top level, message ROM and
// the 28-bit panel register, as seen by the scroll sequencer.
interface painel_scroll_ctrl_if #(
   parameter int MSG_AW = 4
);
   logic              start;
   logic              stop;
   logic [1:0]        mode;
   logic [MSG_AW-1:0] msg_len;
   logic [27:0]       static_word;
   logic [6:0]        char_seg;
   logic [MSG_AW-1:0] char_addr;
   logic              reg_load;
   logic [1:0]        reg_s;
   logic [27:0]       reg_d;
   logic              reg_m_sig;
   logic              busy;
   logic              wrap;
   logic              done;

   modport master (
      output start, stop, mode, msg_len, static_word, char_seg,
      input  char_addr, reg_load, reg_s, reg_d, reg_m_sig, busy, wrap, done
   );

   modport slave (
      input  start, stop, mode, msg_len, static_word, char_seg,
      output char_addr, reg_load, reg_s, reg_d, reg_m_sig, busy, wrap, done
   );
endinterface

// File: rtl/painel_scroll_ctrl.sv
// Panel register sequencer: static parallel load, or fetch ROM segment codes
// and shift them serially into the register with a pause between characters.
module painel_scroll_ctrl #(
   parameter int MSG_AW   = 4,
   parameter int STEP_DIV = 25000000,
   parameter int CNT_W    = 25
) (
   input logic                 clk,
   input logic                 clr,
   painel_scroll_ctrl_if.slave bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_FETCH = 3'd2;
   localparam logic [2:0] S_SHIFT = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;

   logic [2:0]        state;
   logic [MSG_AW-1:0] char_idx;
   logic [2:0]        bit_cnt;
   logic [CNT_W-1:0]  pause_cnt;
   logic [6:0]        sh;
   logic [1:0]        mode_r;
   logic              stop_pend;
   logic              done_r;

   logic start_ok, last_char, bit_last, pause_end, left;

   always_comb begin
      start_ok  = bus.start && !bus.stop && (bus.msg_len != '0) && (bus.mode != 2'b11);
      // An index at or beyond a shrunken msg_len is treated as the last character.
      last_char = ({1'b0, char_idx} + {{MSG_AW{1'b0}}, 1'b1}) >= {1'b0, bus.msg_len};
      bit_last  = (bit_cnt == 3'd6);
      pause_end = (pause_cnt == CNT_W'(STEP_DIV - 1));
      left      = (mode_r == 2'b10);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= S_IDLE;
         char_idx  <= '0;
         bit_cnt   <= '0;
         pause_cnt <= '0;
         sh        <= '0;
         mode_r    <= '0;
         stop_pend <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            S_IDLE: begin
               stop_pend <= 1'b0;
               if (start_ok) begin
                  mode_r <= bus.mode;
                  if (bus.mode == 2'b00) begin
                     state <= S_LOAD;
                  end else begin
                     char_idx <= '0;
                     state    <= S_FETCH;
                  end
               end
            end
            S_LOAD: state <= S_IDLE;
            S_FETCH: begin
               sh      <= bus.char_seg;
               bit_cnt <= '0;
               if (bus.stop) stop_pend <= 1'b1;
               state   <= S_SHIFT;
            end
            S_SHIFT: begin
               sh      <= left ? {sh[5:0], 1'b0} : {1'b0, sh[6:1]};
               bit_cnt <= bit_cnt + 3'd1;
               // A stop is only honoured once the whole character is in.
               if (bit_last) begin
                  char_idx  <= last_char ? '0 : char_idx + {{(MSG_AW-1){1'b0}}, 1'b1};
                  pause_cnt <= '0;
                  if (stop_pend || bus.stop) begin
                     state     <= S_IDLE;
                     done_r    <= 1'b1;
                     stop_pend <= 1'b0;
                  end else begin
                     state <= S_WAIT;
                  end
               end else if (bus.stop) begin
                  stop_pend <= 1'b1;
               end
            end
            S_WAIT: begin
               if (bus.stop) begin
                  state  <= S_IDLE;
                  done_r <= 1'b1;
               end else if (pause_end) begin
                  state <= S_FETCH;
               end else begin
                  pause_cnt <= pause_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.char_addr = char_idx;
      bus.reg_load  = (state == S_LOAD);
      bus.reg_d     = (state == S_LOAD) ? bus.static_word : '0;
      bus.reg_s     = (state == S_SHIFT) ? (left ? 2'b10 : 2'b01) : 2'b00;
      bus.reg_m_sig = (state == S_SHIFT) ? (left ? sh[6] : sh[0]) : 1'b0;
      bus.busy      = (state != S_IDLE);
      bus.wrap      = (state == S_SHIFT) && bit_last && last_char;
      bus.done      = (state == S_LOAD) || done_r;
   end
endmodule

// File: tb/tb_painel_scroll_ctrl.sv
// Directed bench for painel_scroll_ctrl with STEP_DIV=4 and a 3-entry message ROM.
module tb_painel_scroll_ctrl;
   logic clk = 1'b0;
   logic clr;
   int   n_chk  = 0;
   int   n_fail = 0;

   painel_scroll_ctrl_if #(.MSG_AW(4)) bus ();

   painel_scroll_ctrl #(
      .MSG_AW  (4),
      .STEP_DIV(4),
      .CNT_W   (3)
   ) dut (
      .clk(clk),
      .clr(clr),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] rom(input logic [3:0] a);
      case (a)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         default: return 7'h00;
      endcase
   endfunction

   assign bus.char_seg = rom(bus.char_addr);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"},  32'(bus.busy),      32'd0);
      chk({tag, "_load"},  32'(bus.reg_load),  32'd0);
      chk({tag, "_s"},     32'(bus.reg_s),     32'd0);
      chk({tag, "_d"},     32'(bus.reg_d),     32'd0);
      chk({tag, "_msig"},  32'(bus.reg_m_sig), 32'd0);
      chk({tag, "_wrap"},  32'(bus.wrap),      32'd0);
      chk({tag, "_done"},  32'(bus.done),      32'd0);
      chk({tag, "_addr"},  32'(bus.char_addr), 32'd0);
   endtask

   // Runs FETCH of character c then its 7 shift cycles; leaves the bench in shift bit 6.
   task automatic run_char(input string tag, input int c, input bit lft, input bit exp_wrap);
      logic [6:0] v;
      v = rom(4'(c));
      chk({tag, "_fetch_addr"}, 32'(bus.char_addr), 32'(c));
      chk({tag, "_fetch_s"},    32'(bus.reg_s),     32'd0);
      for (int i = 0; i < 7; i++) begin
         tick();
         chk({tag, "_s"},    32'(bus.reg_s), lft ? 32'd2 : 32'd1);
         chk({tag, "_msig"}, 32'(bus.reg_m_sig), 32'(lft ? v[6-i] : v[i]));
         chk({tag, "_wrap"}, 32'(bus.wrap), 32'((i == 6) && exp_wrap));
      end
   endtask

   initial begin
      logic [6:0] v;
      clr = 1'b1;
      bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 2'b00;
      bus.msg_len = 4'd0; bus.static_word = '0;
      tick(); tick();
      clr = 1'b0;
      chk_idle("reset");

      // Static load
      bus.mode = 2'b00; bus.msg_len = 4'd1; bus.static_word = 28'hABCDEF1;
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      chk("st_load", 32'(bus.reg_load), 32'd1);
      chk("st_d",    32'(bus.reg_d),    32'h0ABCDEF1);
      chk("st_done", 32'(bus.done),     32'd1);
      chk("st_busy", 32'(bus.busy),     32'd1);
      tick();
      chk_idle("st_after");

      // Scroll left, 2 chars, then stop in WAIT
      bus.mode = 2'b10; bus.msg_len = 4'd2;
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      run_char("l0", 0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("l_wait_s",    32'(bus.reg_s), 32'd0);
         chk("l_wait_busy", 32'(bus.busy),  32'd1);
      end
      tick();
      run_char("l1", 1, 1'b1, 1'b1);
      tick();
      chk("l_wait2_s", 32'(bus.reg_s), 32'd0);
      bus.stop = 1'b1; tick(); bus.stop = 1'b0;
      chk("wstop_done", 32'(bus.done), 32'd1);
      chk("wstop_busy", 32'(bus.busy), 32'd0);
      tick();
      chk("wstop_done2", 32'(bus.done), 32'd0);

      // Scroll right, 3 chars with wrap
      bus.mode = 2'b01; bus.msg_len = 4'd3;
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         run_char("r", c, 1'b0, c == 2);
         for (int i = 0; i < 4; i++) tick();
         chk("r_wait_end_s", 32'(bus.reg_s), 32'd0);
         tick();
      end
      chk("r_wrap_addr", 32'(bus.char_addr), 32'd0);

      // Stop during 3rd shift bit: character completes, no WAIT
      v = rom(4'd0);
      for (int i = 0; i < 7; i++) begin
         tick();
         if (i == 2) bus.stop = 1'b1;
         if (i == 3) bus.stop = 1'b0;
         chk("sp_s",    32'(bus.reg_s), 32'd1);
         chk("sp_msig", 32'(bus.reg_m_sig), 32'(v[i]));
      end
      tick();
      chk("sp_done", 32'(bus.done),  32'd1);
      chk("sp_busy", 32'(bus.busy),  32'd0);
      chk("sp_s_end", 32'(bus.reg_s), 32'd0);
      chk("sp_addr", 32'(bus.char_addr), 32'd1);

      // Clear mid-shift
      bus.mode = 2'b10; bus.msg_len = 4'd2;
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      tick(); tick();
      chk("clr_pre_msig", 32'(bus.reg_m_sig), 32'd1);
      chk("clr_pre_s",    32'(bus.reg_s),     32'd2);
      clr = 1'b1; tick(); clr = 1'b0;
      chk_idle("clr");
      tick();
      chk("clr_stay", 32'(bus.busy), 32'd0);

      // Rejected starts
      bus.stop = 1'b1; bus.start = 1'b1; tick(); bus.start = 1'b0; bus.stop = 1'b0;
      chk("rej_stop", 32'(bus.busy), 32'd0);
      bus.msg_len = 4'd0; bus.start = 1'b1; tick(); bus.start = 1'b0;
      chk("rej_len0", 32'(bus.busy), 32'd0);
      bus.msg_len = 4'd2; bus.mode = 2'b11; bus.start = 1'b1; tick(); bus.start = 1'b0;
      chk("rej_mode3", 32'(bus.busy), 32'd0);

      // Start while busy in WAIT is ignored
      bus.mode = 2'b01; bus.msg_len = 4'd3;
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      run_char("b0", 0, 1'b0, 1'b0);
      tick();
      bus.mode = 2'b10; bus.start = 1'b1; tick(); bus.start = 1'b0;
      chk("busy_s",    32'(bus.reg_s), 32'd0);
      chk("busy_busy", 32'(bus.busy),  32'd1);
      tick(); tick(); tick();
      run_char("b1", 1, 1'b0, 1'b0);
      tick();
      bus.stop = 1'b1; tick(); bus.stop = 1'b0;
      chk("busy_end", 32'(bus.busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
